jam_cost_loader: RTL and testbench



---
 rtl/jam_cost_loader.sv | 112 +++++++++++
 tb/tb_jam_cost_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/jam_cost_loader.sv
// jam_cost_loader: streams an 8x8 cost matrix into a register file and serves
// registered (W,J) lookups for the JAM. Optional row-minimum lower bound.
//
// Ports:
//   CLK, RST (async, active-low)
//   in_valid/in_ready/in_data : row-major cost stream (entry k = worker k/8, job k%8)
//   clear                     : discard the table and restart the load
//   W, J                      : lookup address; Cost is table[W][J] one cycle later
//   table_ready               : all 64 entries loaded
//   LowerBound                : sum of the row minima while table_ready (else 0)
// Build option: define JAM_COST_LB_EN to compile in the row-minimum accumulator;
// without it LowerBound is tied to 0.
module jam_cost_loader #(
  parameter int CW = 7
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_data,
  input  logic          clear,
  input  logic [2:0]    W,
  input  logic [2:0]    J,
  output logic [CW-1:0] Cost,
  output logic          table_ready,
  output logic [9:0]    LowerBound
);

  typedef enum logic {
    LOAD  = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t        state;
  state_t        state_n;
  logic          xfer;
  logic [5:0]    wptr;
  logic [CW-1:0] mem [64];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= LOAD;
    else      state <= state_n;
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    xfer     = 1'b0;
    unique case (state)
      LOAD: begin
        in_ready = !clear;
        xfer     = in_valid && !clear;
        if (xfer && wptr == 6'd63) state_n = SERVE;
      end
      SERVE: begin
        if (clear) state_n = LOAD;
      end
    endcase
  end

  assign table_ready = (state == SERVE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)      wptr <= '0;
    else if (clear) wptr <= '0;
    else if (xfer)  wptr <= wptr + 6'd1;
  end

  // Storage is deliberately not reset; Cost masks it outside SERVE.
  always_ff @(posedge CLK) begin
    if (xfer) mem[wptr] <= in_data;
  end

  // A clear in SERVE already zeroes Cost on the edge that leaves SERVE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      Cost <= '0;
    else if (state == SERVE && !clear)
      Cost <= mem[{W, J}];
    else
      Cost <= '0;
  end

`ifdef JAM_COST_LB_EN
  logic [CW-1:0] row_min;
  logic [CW-1:0] row_lo;
  logic [9:0]    acc;

  assign row_lo = (in_data < row_min) ? in_data : row_min;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      row_min <= '0;
      acc     <= '0;
    end else if (clear) begin
      row_min <= '0;
      acc     <= '0;
    end else if (xfer) begin
      if (wptr[2:0] == 3'd0) row_min <= in_data;
      else                   row_min <= row_lo;
      // j==0 and j==7 never coincide, so row_lo is the true row minimum here.
      if (wptr[2:0] == 3'd7)
        acc <= acc + {{(10-CW){1'b0}}, row_lo};
    end
  end

  assign LowerBound = table_ready ? acc : 10'd0;
`else
  assign LowerBound = 10'd0;
`endif

endmodule

// File: tb/tb_jam_cost_loader.sv
// tb_jam_cost_loader: directed scoreboard bench for jam_cost_loader.
// Stimulus pushes expected values tagged with a cycle; a monitor pops them.
module tb_jam_cost_loader;

  localparam int CW = 7;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_data = '0;
  logic          clear = 1'b0;
  logic [2:0]    W = '0;
  logic [2:0]    J = '0;
  logic [CW-1:0] Cost;
  logic          table_ready;
  logic [9:0]    LowerBound;

  jam_cost_loader #(.CW(CW)) dut (
    .CLK(CLK),
    .RST(RST),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .clear(clear),
    .W(W),
    .J(J),
    .Cost(Cost),
    .table_ready(table_ready),
    .LowerBound(LowerBound)
  );

  always #5 CLK = ~CLK;

  typedef enum int {K_COST, K_TR, K_LB, K_RDY} kind_t;
  typedef struct {
    int    cyc;
    kind_t kind;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  int   model[64];

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int dut_val(kind_t k);
    case (k)
      K_COST:  return int'(Cost);
      K_TR:    return int'(table_ready);
      K_LB:    return int'(LowerBound);
      default: return int'(in_ready);
    endcase
  endfunction

  initial begin
    forever begin
      @(negedge CLK or negedge RST);
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        int   act;
        e   = sb.pop_front();
        act = dut_val(e.kind);
        total++;
        if (act == e.val) passed++;
        else $display("FAIL %s cyc=%0d got %0d expected %0d",
                      e.name, cyc, act, e.val);
      end
    end
  end

  task automatic push(input int c, input kind_t k, input int v,
                      input string n);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic int exp_lb();
    int s;
    s = 0;
`ifdef JAM_COST_LB_EN
    for (int w = 0; w < 8; w++) begin
      int m;
      m = model[w*8];
      for (int j = 1; j < 8; j++)
        if (model[w*8+j] < m) m = model[w*8+j];
      s += m;
    end
`endif
    return s;
  endfunction

  task automatic load(input bit bubble);
    int n;
    int i;
    n = 0;
    i = 0;
    while (n < 64) begin
      in_valid = !(bubble && (i % 3 == 2));
      in_data  = CW'(model[n]);
      if (in_valid) begin
        n++;
        if (n == 1) push(cyc, K_RDY, 1, "load_ready");
        if (n == 64) begin
          push(cyc, K_TR, 0, "tr_before_last");
          push(cyc + 1, K_TR, 1, "tr_rise");
          push(cyc + 1, K_LB, exp_lb(), "lower_bound");
        end
      end
      if (i == 10) begin
        push(cyc + 1, K_COST, 0, "cost_in_load");
        push(cyc + 1, K_LB, 0, "lb_in_load");
      end
      tick();
      i++;
    end
    in_valid = 1'b0;
  endtask

  task automatic read(input int w, input int j, input string n);
    W = 3'(w);
    J = 3'(j);
    push(cyc + 1, K_COST, model[w*8+j], n);
    tick();
  endtask

  task automatic sweep;
    for (int k = 0; k < 64; k++) read(k / 8, k % 8, "sweep");
  endtask

  task automatic serve_clear;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    push(cyc, K_RDY, 1, "rst_ready");
    push(cyc, K_TR, 0, "rst_tr");
    push(cyc, K_LB, 0, "rst_lb");
    push(cyc, K_COST, 0, "rst_cost");
    tick();

    for (int k = 0; k < 64; k++) model[k] = 10 * (k / 8) + (k % 8);
    load(1'b0);
    read(3, 5, "cost_3_5");
    sweep();

    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 7'd99;
    push(cyc, K_RDY, 0, "clr_serve_rdy");
    push(cyc + 1, K_TR, 0, "clr_serve_tr");
    push(cyc + 1, K_COST, 0, "clr_serve_cost");
    push(cyc + 1, K_LB, 0, "clr_serve_lb");
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    push(cyc, K_RDY, 1, "rdy_after_clr");
    tick();

    load(1'b1);
    sweep();

    serve_clear();
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_data  = 7'd1;
      tick();
    end
    clear = 1'b1;
    push(cyc, K_RDY, 0, "clr_load_rdy");
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 64; k++) model[k] = 127;
    model[50] = 4;
    load(1'b0);
    read(6, 2, "cost_6_2");
    read(0, 0, "cost_0_0");
    read(7, 7, "cost_7_7");

    read(6, 2, "pre_rst_cost");
    @(negedge CLK);
    #2;
    push(cyc, K_COST, 0, "async_rst_cost");
    push(cyc, K_TR, 0, "async_rst_tr");
    push(cyc, K_LB, 0, "async_rst_lb");
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    push(cyc, K_RDY, 1, "rel_ready");
    tick();

    for (int k = 0; k < 64; k++) model[k] = 127 - (10 * (k / 8) + (k % 8));
    load(1'b0);
    read(0, 0, "reload_0_0");
    read(3, 5, "reload_3_5");
    read(7, 7, "reload_7_7");

    repeat (2) tick();
    if (sb.size() != 0) begin
      $display("FAIL unchecked got %0d pending expected 0", sb.size());
      total += sb.size();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
